// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - opcodes, ALU operations and instruction layout for the sm CPU
package sm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_OR,
        ALU_SRL,
        ALU_SLTU,
        ALU_SUB,
        ALU_LUI
    } alu_op_e;

    // R-type view; I-type immediate is the low 16 bits {rd, shamt, funct}
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [15:0] imm16(input instr_t i);
        return {i.rd, i.shamt, i.funct};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sm_clk_divider.sv
// rtl/sm_clk_divider.sv - power-of-two core clock divider with enable and bypass
module sm_clk_divider #(
    parameter int SHIFT  = 16,
    parameter bit bypass = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] devide_i,
    input  logic       enable_i,
    output logic       clk_o
);

    logic [31:0] cntr_q;
    logic [31:0] cntr_d;
    logic [4:0]  sel;

    assign cntr_d = cntr_q + 32'd1;

    // free-running counter; its selected bit is the divided clock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cntr_q <= '0;
        end else begin
            cntr_q <= cntr_d;
        end
    end

    assign sel   = 5'(SHIFT) + {1'b0, devide_i};
    assign clk_o = bypass ? clk_i : (enable_i & cntr_q[sel]);

endmodule

// File: rtl/sm_top.sv
// rtl/sm_top.sv - single-cycle MIPS-subset core with ROM, regfile, ALU and clock divider
module sm_top
    import sm_pkg::*;
#(
    parameter int    ROM_DEPTH = 64,
    parameter string ROM_FILE  = "program.hex",
    parameter int    SHIFT     = 16,
    parameter bit    BYPASS    = 1'b0
) (
    input  logic        clkIn,
    input  logic        rst_p,
    input  logic [3:0]  clkDevide,
    input  logic        clkEnable,
    output logic        clk,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int PC_W   = ROM_AW + 2;

    sm_clk_divider #(
        .SHIFT  (SHIFT),
        .bypass (BYPASS)
    ) sm_clk_divider (
        .clk_i    (clkIn),
        .rst_i    (rst_p),
        .devide_i (clkDevide),
        .enable_i (clkEnable),
        .clk_o    (clk)
    );

    logic [31:0]     rom [ROM_DEPTH];
    logic [31:0]     rf_q [32];
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    instr_t      instr;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic        is_beq;
    logic        is_bne;
    logic        taken;

    // PC width equals the ROM byte span, so PC arithmetic wraps with the ROM
    assign instr  = instr_t'(rom[pc_q[PC_W-1:2]]);
    assign imm    = imm16(instr);
    assign rs_val = (instr.rs == 5'd0) ? 32'd0 : rf_q[instr.rs];
    assign rt_val = (instr.rt == 5'd0) ? 32'd0 : rf_q[instr.rt];

    // decode: unsupported encodings fall through as nops (no write, no branch)
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        reg_we  = 1'b0;
        wr_addr = instr.rd;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        case (instr.op)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (instr.funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SUBU: alu_op = ALU_SUB;
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                wr_addr = instr.rt;
            end
            OP_LUI: begin
                alu_op  = ALU_LUI;
                reg_we  = 1'b1;
                wr_addr = instr.rt;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = use_imm ? sext16(imm) : rt_val;

    // ALU: 32-bit wrapping arithmetic, srl shifts rt by shamt
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_y = rs_val + alu_b;
            ALU_OR:   alu_y = rs_val | alu_b;
            ALU_SRL:  alu_y = rt_val >> instr.shamt;
            ALU_SLTU: alu_y = {31'd0, (rs_val < alu_b)};
            ALU_SUB:  alu_y = rs_val - alu_b;
            ALU_LUI:  alu_y = {imm, 16'd0};
            default:  alu_y = 32'd0;
        endcase
    end

    assign taken = (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val));
    assign pc_d  = pc_q + PC_W'(4) + (taken ? PC_W'({imm, 2'b00}) : '0);

    // program counter, returned to 0 as soon as reset rises
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // register file write port; $0 is never stored and contents survive reset
    always_ff @(posedge clk) begin
        if (reg_we && (wr_addr != 5'd0)) begin
            rf_q[wr_addr] <= alu_y;
        end
    end

    assign regData = (regAddr == 5'd0) ? 32'd0 : rf_q[regAddr];

endmodule

// File: tb/tb_sm_top.sv
// tb/tb_sm_top.sv - directed self-checking bench for sm_top
module tb_sm_top;

    logic        clkIn;
    logic        rst_p;
    logic        rst_b;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        clk_a;
    logic        clk_b;
    logic        clkEnable_b;
    logic [31:0] regData_b;

    int n_checks = 0;
    int n_fail   = 0;

    sm_top #(
        .ROM_DEPTH (64),
        .ROM_FILE  (""),
        .SHIFT     (16),
        .BYPASS    (1'b1)
    ) dut_a (
        .clkIn     (clkIn),
        .rst_p     (rst_p),
        .clkDevide (4'd0),
        .clkEnable (1'b1),
        .clk       (clk_a),
        .regAddr   (regAddr),
        .regData   (regData)
    );

    sm_top #(
        .ROM_DEPTH (64),
        .ROM_FILE  (""),
        .SHIFT     (0),
        .BYPASS    (1'b0)
    ) dut_b (
        .clkIn     (clkIn),
        .rst_p     (rst_b),
        .clkDevide (4'd0),
        .clkEnable (clkEnable_b),
        .clk       (clk_b),
        .regAddr   (5'd0),
        .regData   (regData_b)
    );

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_roms();
        for (int i = 0; i < 64; i++) begin
            dut_a.rom[i] = 32'h0;
            dut_b.rom[i] = 32'h0;
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut_a.rom[idx] = w;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic restart_a();
        @(negedge clkIn);
        rst_p = 1'b1;
        #1;
        check("restart_pc", 32'(dut_a.pc_q), 32'd0);
        clear_roms();
    endtask

    task automatic release_a();
        @(negedge clkIn);
        rst_p = 1'b0;
    endtask

    task automatic load_countdown();
        put(0, 32'h24060003);
        put(1, 32'h24C6FFFF);
        put(2, 32'h14C0FFFE);
        put(3, 32'h1000FFFF);
    endtask

    initial begin
        rst_p       = 1'b1;
        rst_b       = 1'b1;
        regAddr     = 5'd0;
        clkEnable_b = 1'b1;
        clear_roms();
        put(0, 32'h24060005);
        put(1, 32'h24C60002);
        put(2, 32'h1000FFFF);

        // reset state and PC stepping
        step(2);
        check("reset_pc", 32'(dut_a.pc_q), 32'd0);
        check("reset_r0", regData, 32'd0);
        regAddr = 5'd6;
        #2;
        rst_p = 1'b0;
        rst_b = 1'b0;
        step(1);
        check("step1_pc", 32'(dut_a.pc_q), 32'd4);
        check("step1_r6", regData, 32'd5);
        step(1);
        check("step2_pc", 32'(dut_a.pc_q), 32'd8);
        check("addiu_r6", regData, 32'd7);
        step(2);
        check("halt_pc", 32'(dut_a.pc_q), 32'd8);

        // lui / or / sltu / subu / srl / addu and $0 discard
        restart_a();
        put(0,  32'h3C061234);
        put(1,  32'h00C03025);
        put(2,  32'h24070001);
        put(3,  32'h24080002);
        put(4,  32'h00E8482B);
        put(5,  32'h00073023);
        put(6,  32'h00065102);
        put(7,  32'h00E85821);
        put(8,  32'h0107602B);
        put(9,  32'h24000005);
        put(10, 32'h1000FFFF);
        release_a();
        step(2);
        check("lui_or_r6", regData, 32'h1234_0000);
        step(4);
        check("subu_r6", regData, 32'hFFFF_FFFF);
        step(6);
        check("progb_halt_pc", 32'(dut_a.pc_q), 32'd40);
        regAddr = 5'd9;  #1; check("sltu_1_2", regData, 32'd1);
        regAddr = 5'd10; #1; check("srl_r10", regData, 32'h0FFF_FFFF);
        regAddr = 5'd11; #1; check("addu_r11", regData, 32'd3);
        regAddr = 5'd12; #1; check("sltu_2_1", regData, 32'd0);
        regAddr = 5'd0;  #1; check("r0_discard", regData, 32'd0);
        regAddr = 5'd6;

        // countdown loop to halt
        restart_a();
        load_countdown();
        release_a();
        step(10);
        check("loop_r6", regData, 32'd0);
        check("loop_halt_pc", 32'(dut_a.pc_q), 32'd12);
        step(3);
        check("loop_frozen_pc", 32'(dut_a.pc_q), 32'd12);

        // asynchronous reset mid-loop keeps registers
        restart_a();
        load_countdown();
        release_a();
        step(3);
        check("mid_pc", 32'(dut_a.pc_q), 32'd4);
        check("mid_r6", regData, 32'd2);
        rst_p = 1'b1;
        #1;
        check("async_rst_pc", 32'(dut_a.pc_q), 32'd0);
        check("rst_kept_r6", regData, 32'd2);
        release_a();
        step(10);
        check("rerun_r6", regData, 32'd0);
        check("rerun_pc", 32'(dut_a.pc_q), 32'd12);

        // divided clock: SHIFT=0, clkDevide=0 -> period 2x clkIn
        @(negedge clkIn);
        rst_b = 1'b1;
        #1;
        check("b_rst_pc", 32'(dut_b.pc_q), 32'd0);
        @(negedge clkIn);
        rst_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clkIn);
            check($sformatf("div_clk_%0d", k), 32'(clk_b), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("div_pc_%0d", k), 32'(dut_b.pc_q), (k <= 2) ? 32'd4 : 32'd8);
        end
        clkEnable_b = 1'b0;
        #1;
        check("dis_clk_now", 32'(clk_b), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clkIn);
            check($sformatf("dis_clk_%0d", k), 32'(clk_b), 32'd0);
            check($sformatf("dis_pc_%0d", k), 32'(dut_b.pc_q), 32'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
